// File: rtl/wb_retire.sv
// Writeback/retire unit: two-entry in-order skid buffer feeding the register-file write port.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module wb_retire #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n,
    // Handshake: a result transfers on a rising edge where M_valid_i && M_ready_o.
    // M_ready_o depends only on registered occupancy, never on this cycle's pop.
    input  logic            M_valid_i,
    output logic            M_ready_o,
    input  logic            M_need_dstE_i,
    input  logic [4:0]      M_dstE_i,
    input  logic [XLEN-1:0] M_valE_i,
    input  logic [XLEN-1:0] M_valM_i,
    input  logic            M_is_load_i,
    input  logic [2:0]      M_funct3_i,
    input  logic            dbg_we_i,
    input  logic [4:0]      dbg_addr_i,
    input  logic [XLEN-1:0] dbg_data_i,
    output logic            W_valid_o,
    output logic            W_need_dstE_o,
    output logic [4:0]      W_dstE_o,
    output logic [XLEN-1:0] W_data_o,
    output logic [31:0]     W_busy_o
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]     instret_o
`endif
);

    typedef struct packed {
        logic            need;
        logic [4:0]      dst;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t          buf_q [2];
    logic            head_q;
    logic            tail_q;
    logic [1:0]      count_q;
    logic [4:0]      last_dst_q;
    logic [XLEN-1:0] last_data_q;
    logic            push;
    logic            pop;
    logic [1:0]      slot_vld;
    entry_t          in_entry;
    entry_t          head_entry;

    function automatic logic [XLEN-1:0] fmt_load(input logic [2:0] f3,
                                                input logic [1:0] off,
                                                input logic [XLEN-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = w[16*off[1] +: 16];
        case (f3)
            3'b000:  return {{(XLEN-8){b[7]}}, b};
            3'b001:  return {{(XLEN-16){h[15]}}, h};
            3'b100:  return {{(XLEN-8){1'b0}}, b};
            3'b101:  return {{(XLEN-16){1'b0}}, h};
            default: return w;
        endcase
    endfunction

    assign M_ready_o  = rst_n & (count_q != 2'd2);
    assign push       = M_valid_i & M_ready_o;
    // Debug owns the port outright; the head simply waits.
    assign pop        = rst_n & ~dbg_we_i & (count_q != 2'd0);
    assign head_entry = buf_q[head_q];

    always_comb begin
        in_entry.need = M_need_dstE_i;
        in_entry.dst  = M_dstE_i;
        in_entry.data = M_is_load_i ? fmt_load(M_funct3_i, M_valE_i[1:0], M_valM_i) : M_valE_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                buf_q[tail_q] <= in_entry;
                tail_q        <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        W_valid_o     = 1'b0;
        W_need_dstE_o = 1'b0;
        W_dstE_o      = last_dst_q;
        W_data_o      = last_data_q;
        if (rst_n) begin
            if (dbg_we_i) begin
                W_valid_o     = 1'b1;
                W_need_dstE_o = 1'b1;
                W_dstE_o      = dbg_addr_i;
                W_data_o      = dbg_data_i;
            end else if (count_q != 2'd0) begin
                W_valid_o     = 1'b1;
                W_need_dstE_o = head_entry.need;
                W_dstE_o      = head_entry.dst;
                W_data_o      = head_entry.data;
            end
        end
    end

    // Idle cycles keep showing the last index/data driven on the port.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            last_dst_q  <= 5'd0;
            last_data_q <= '0;
        end else if (W_valid_o) begin
            last_dst_q  <= W_dstE_o;
            last_data_q <= W_data_o;
        end
    end

    always_comb begin
        case (count_q)
            2'd2:    slot_vld = 2'b11;
            2'd1:    slot_vld = head_q ? 2'b10 : 2'b01;
            default: slot_vld = 2'b00;
        endcase
    end

    always_comb begin
        W_busy_o = '0;
        for (int s = 0; s < 2; s++) begin
            if (slot_vld[s] && buf_q[s].need) begin
                W_busy_o[buf_q[s].dst] = 1'b1;
            end
        end
        W_busy_o[0] = 1'b0;
    end

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (pop) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret_o = instret_q;
`endif

endmodule

// File: tb/tb_wb_retire.sv
// Directed self-checking bench for wb_retire: reset, load formatting, debug priority,
// streaming, busy mask, and (with WB_INSTRET_EN) counter wrap.
module tb_wb_retire;

    logic        clk_i;
    logic        rst_n;
    logic        M_valid_i;
    logic        M_ready_o;
    logic        M_need_dstE_i;
    logic [4:0]  M_dstE_i;
    logic [31:0] M_valE_i;
    logic [31:0] M_valM_i;
    logic        M_is_load_i;
    logic [2:0]  M_funct3_i;
    logic        dbg_we_i;
    logic [4:0]  dbg_addr_i;
    logic [31:0] dbg_data_i;
    logic        W_valid_o;
    logic        W_need_dstE_o;
    logic [4:0]  W_dstE_o;
    logic [31:0] W_data_o;
    logic [31:0] W_busy_o;
`ifdef WB_INSTRET_EN
    logic [63:0] instret_o;
`endif

    int checks = 0;
    int errors = 0;

    wb_retire #(.XLEN(32)) dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .M_valid_i     (M_valid_i),
        .M_ready_o     (M_ready_o),
        .M_need_dstE_i (M_need_dstE_i),
        .M_dstE_i      (M_dstE_i),
        .M_valE_i      (M_valE_i),
        .M_valM_i      (M_valM_i),
        .M_is_load_i   (M_is_load_i),
        .M_funct3_i    (M_funct3_i),
        .dbg_we_i      (dbg_we_i),
        .dbg_addr_i    (dbg_addr_i),
        .dbg_data_i    (dbg_data_i),
        .W_valid_o     (W_valid_o),
        .W_need_dstE_o (W_need_dstE_o),
        .W_dstE_o      (W_dstE_o),
        .W_data_o      (W_data_o),
        .W_busy_o      (W_busy_o)
`ifdef WB_INSTRET_EN
        ,
        .instret_o     (instret_o)
`endif
    );

    // Clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Driver tasks
    task automatic drive_idle();
        M_valid_i     = 1'b0;
        M_need_dstE_i = 1'b0;
        M_dstE_i      = 5'd0;
        M_valE_i      = 32'd0;
        M_valM_i      = 32'd0;
        M_is_load_i   = 1'b0;
        M_funct3_i    = 3'd0;
        dbg_we_i      = 1'b0;
        dbg_addr_i    = 5'd0;
        dbg_data_i    = 32'd0;
    endtask

    task automatic set_push(input logic need, input logic [4:0] dst, input logic [31:0] vale,
                            input logic [31:0] valm, input logic isl, input logic [2:0] f3);
        M_valid_i     = 1'b1;
        M_need_dstE_i = need;
        M_dstE_i      = dst;
        M_valE_i      = vale;
        M_valM_i      = valm;
        M_is_load_i   = isl;
        M_funct3_i    = f3;
    endtask

    task automatic clear_push();
        M_valid_i = 1'b0;
    endtask

    task automatic set_dbg(input logic we, input logic [4:0] addr, input logic [31:0] data);
        dbg_we_i   = we;
        dbg_addr_i = addr;
        dbg_data_i = data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        set_dbg(1'b1, 5'd9, 32'h55);
        #1;
        checks++; if (W_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", W_valid_o); end
        checks++; if (W_need_dstE_o !== 1'b0) begin errors++; $display("FAIL rst_need: got %0b want 0", W_need_dstE_o); end
        checks++; if (M_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b want 0", M_ready_o); end
        checks++; if (W_busy_o !== 32'd0) begin errors++; $display("FAIL rst_busy: got %h want 0", W_busy_o); end
        @(negedge clk_i);
        set_dbg(1'b0, 5'd0, 32'd0);
        #1;
        checks++; if (W_dstE_o !== 5'd0) begin errors++; $display("FAIL rst_dst: got %0d want 0", W_dstE_o); end
        checks++; if (W_data_o !== 32'd0) begin errors++; $display("FAIL rst_data: got %h want 0", W_data_o); end
`ifdef WB_INSTRET_EN
        checks++; if (instret_o !== 64'd0) begin errors++; $display("FAIL rst_instret: got %0d want 0", instret_o); end
`endif
        rst_n = 1'b1;
        #1;
        checks++; if (M_ready_o !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %0b want 1", M_ready_o); end
        checks++; if (W_valid_o !== 1'b0) begin errors++; $display("FAIL rst_release_valid: got %0b want 0", W_valid_o); end
    endtask

    task automatic test_basic();
        @(negedge clk_i);
        set_push(1'b1, 5'd5, 32'h1234, 32'h0, 1'b0, 3'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        clear_push();
        #1;
        checks++; if (W_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b want 1", W_valid_o); end
        checks++; if (W_need_dstE_o !== 1'b1) begin errors++; $display("FAIL basic_need: got %0b want 1", W_need_dstE_o); end
        checks++; if (W_dstE_o !== 5'd5) begin errors++; $display("FAIL basic_dst: got %0d want 5", W_dstE_o); end
        checks++; if (W_data_o !== 32'h1234) begin errors++; $display("FAIL basic_data: got %h want 00001234", W_data_o); end
        checks++; if (W_busy_o !== 32'h20) begin errors++; $display("FAIL basic_busy: got %h want 00000020", W_busy_o); end
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        checks++; if (W_valid_o !== 1'b0) begin errors++; $display("FAIL basic_idle_valid: got %0b want 0", W_valid_o); end
        checks++; if (W_need_dstE_o !== 1'b0) begin errors++; $display("FAIL basic_idle_need: got %0b want 0", W_need_dstE_o); end
        checks++; if (W_dstE_o !== 5'd5) begin errors++; $display("FAIL basic_hold_dst: got %0d want 5", W_dstE_o); end
        checks++; if (W_data_o !== 32'h1234) begin errors++; $display("FAIL basic_hold_data: got %h want 00001234", W_data_o); end
        checks++; if (W_busy_o !== 32'h0) begin errors++; $display("FAIL basic_idle_busy: got %h want 0", W_busy_o); end
`ifdef WB_INSTRET_EN
        checks++; if (instret_o !== 64'd1) begin errors++; $display("FAIL basic_instret: got %0d want 1", instret_o); end
`endif
    endtask

    task automatic test_load_format();
        logic [2:0]  f3  [9];
        logic [31:0] ve  [9];
        logic [31:0] vm  [9];
        logic        isl [9];
        logic [31:0] exp [9];
        f3[0] = 3'b000; ve[0] = 32'h1003; vm[0] = 32'h80FF_0000; isl[0] = 1; exp[0] = 32'hFFFF_FF80;
        f3[1] = 3'b100; ve[1] = 32'h1003; vm[1] = 32'h80FF_0000; isl[1] = 1; exp[1] = 32'h0000_0080;
        f3[2] = 3'b001; ve[2] = 32'h1002; vm[2] = 32'h80FF_0000; isl[2] = 1; exp[2] = 32'hFFFF_80FF;
        f3[3] = 3'b101; ve[3] = 32'h1002; vm[3] = 32'h80FF_0000; isl[3] = 1; exp[3] = 32'h0000_80FF;
        f3[4] = 3'b010; ve[4] = 32'h1000; vm[4] = 32'h80FF_0000; isl[4] = 1; exp[4] = 32'h80FF_0000;
        f3[5] = 3'b000; ve[5] = 32'h1001; vm[5] = 32'h0000_7F00; isl[5] = 1; exp[5] = 32'h0000_007F;
        f3[6] = 3'b011; ve[6] = 32'h1000; vm[6] = 32'hDEAD_BEEF; isl[6] = 1; exp[6] = 32'hDEAD_BEEF;
        f3[7] = 3'b000; ve[7] = 32'hCAFE_0001; vm[7] = 32'h1234_5678; isl[7] = 0; exp[7] = 32'hCAFE_0001;
        f3[8] = 3'b001; ve[8] = 32'h1000; vm[8] = 32'h0000_8001; isl[8] = 1; exp[8] = 32'hFFFF_8001;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_i);
            set_push(1'b1, 5'd10, ve[i], vm[i], isl[i], f3[i]);
            @(posedge clk_i);
            @(negedge clk_i);
            clear_push();
            #1;
            checks++;
            if (W_valid_o !== 1'b1 || W_data_o !== exp[i]) begin
                errors++;
                $display("FAIL load_fmt[%0d]: got valid=%0b data=%h want valid=1 data=%h", i, W_valid_o, W_data_o, exp[i]);
            end
            @(posedge clk_i);
        end
    endtask

    task automatic test_debug_priority();
        @(negedge clk_i);
        set_dbg(1'b1, 5'd7, 32'hAA);
        set_push(1'b1, 5'd1, 32'h11, 32'h0, 1'b0, 3'd0);
        #1;
        checks++; if (W_valid_o !== 1'b1 || W_dstE_o !== 5'd7 || W_data_o !== 32'hAA || W_need_dstE_o !== 1'b1)
            begin errors++; $display("FAIL dbg_cycle0: got v=%0b n=%0b d=%0d x=%h want 1 1 7 aa", W_valid_o, W_need_dstE_o, W_dstE_o, W_data_o); end
        checks++; if (M_ready_o !== 1'b1) begin errors++; $display("FAIL dbg_ready0: got %0b want 1", M_ready_o); end
        @(posedge clk_i);
        @(negedge clk_i);
        set_push(1'b1, 5'd2, 32'h22, 32'h0, 1'b0, 3'd0);
        #1;
        checks++; if (W_dstE_o !== 5'd7 || W_data_o !== 32'hAA) begin errors++; $display("FAIL dbg_cycle1: got d=%0d x=%h want 7 aa", W_dstE_o, W_data_o); end
        checks++; if (M_ready_o !== 1'b1) begin errors++; $display("FAIL dbg_ready1: got %0b want 1", M_ready_o); end
        @(posedge clk_i);
        @(negedge clk_i);
        set_push(1'b1, 5'd4, 32'h33, 32'h0, 1'b0, 3'd0);
        #1;
        checks++; if (W_valid_o !== 1'b1 || W_dstE_o !== 5'd7 || W_data_o !== 32'hAA) begin errors++; $display("FAIL dbg_cycle2: got v=%0b d=%0d x=%h want 1 7 aa", W_valid_o, W_dstE_o, W_data_o); end
        checks++; if (M_ready_o !== 1'b0) begin errors++; $display("FAIL dbg_ready_full: got %0b want 0", M_ready_o); end
        checks++; if (W_busy_o !== 32'h6) begin errors++; $display("FAIL dbg_busy: got %h want 00000006", W_busy_o); end
        @(posedge clk_i);
        @(negedge clk_i);
        set_dbg(1'b0, 5'd0, 32'd0);
        #1;
        checks++; if (W_valid_o !== 1'b1 || W_dstE_o !== 5'd1 || W_data_o !== 32'h11) begin errors++; $display("FAIL dbg_retire_a: got v=%0b d=%0d x=%h want 1 1 11", W_valid_o, W_dstE_o, W_data_o); end
        checks++; if (M_ready_o !== 1'b0) begin errors++; $display("FAIL dbg_ready_still_full: got %0b want 0", M_ready_o); end
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        checks++; if (W_valid_o !== 1'b1 || W_dstE_o !== 5'd2 || W_data_o !== 32'h22) begin errors++; $display("FAIL dbg_retire_b: got v=%0b d=%0d x=%h want 1 2 22", W_valid_o, W_dstE_o, W_data_o); end
        checks++; if (M_ready_o !== 1'b1) begin errors++; $display("FAIL dbg_ready_reopen: got %0b want 1", M_ready_o); end
        @(posedge clk_i);
        @(negedge clk_i);
        clear_push();
        #1;
        checks++; if (W_valid_o !== 1'b1 || W_dstE_o !== 5'd4 || W_data_o !== 32'h33) begin errors++; $display("FAIL dbg_retire_c: got v=%0b d=%0d x=%h want 1 4 33", W_valid_o, W_dstE_o, W_data_o); end
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        checks++; if (W_valid_o !== 1'b0) begin errors++; $display("FAIL dbg_drained: got %0b want 0", W_valid_o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q [$];
        logic [31:0] exp_v;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            set_push(1'b1, 5'(i + 1), 32'h100 + 32'(i), 32'h0, 1'b0, 3'd0);
            #1;
            checks++; if (M_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %0b want 1", i, M_ready_o); end
            if (i > 0) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (W_valid_o !== 1'b1 || W_data_o !== exp_v || W_dstE_o !== 5'(i)) begin
                    errors++;
                    $display("FAIL b2b_retire[%0d]: got v=%0b d=%0d x=%h want 1 %0d %h", i, W_valid_o, W_dstE_o, W_data_o, i, exp_v);
                end
            end
            exp_q.push_back(32'h100 + 32'(i));
            @(posedge clk_i);
        end
        @(negedge clk_i);
        clear_push();
        #1;
        exp_v = exp_q.pop_front();
        checks++; if (W_valid_o !== 1'b1 || W_data_o !== exp_v || W_dstE_o !== 5'd6) begin errors++; $display("FAIL b2b_last: got v=%0b d=%0d x=%h want 1 6 %h", W_valid_o, W_dstE_o, W_data_o, exp_v); end
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        checks++; if (W_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %0b want 0", W_valid_o); end
    endtask

    task automatic test_busy_reset();
        @(negedge clk_i);
        set_dbg(1'b1, 5'd12, 32'h77);
        set_push(1'b1, 5'd3, 32'h3333, 32'h0, 1'b0, 3'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        set_push(1'b1, 5'd0, 32'h0000, 32'h0, 1'b0, 3'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        clear_push();
        #1;
        checks++; if (W_busy_o !== 32'h8) begin errors++; $display("FAIL busy_mask: got %h want 00000008", W_busy_o); end
        checks++; if (M_ready_o !== 1'b0) begin errors++; $display("FAIL busy_full: got %0b want 0", M_ready_o); end
        rst_n = 1'b0;
        set_dbg(1'b0, 5'd0, 32'd0);
        #1;
        checks++; if (W_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0b want 0", W_valid_o); end
        @(posedge clk_i);
        @(negedge clk_i);
        rst_n = 1'b1;
        #1;
        checks++; if (W_valid_o !== 1'b0 || W_need_dstE_o !== 1'b0) begin errors++; $display("FAIL midrst_port: got v=%0b n=%0b want 0 0", W_valid_o, W_need_dstE_o); end
        checks++; if (W_dstE_o !== 5'd0 || W_data_o !== 32'd0) begin errors++; $display("FAIL midrst_hold: got d=%0d x=%h want 0 0", W_dstE_o, W_data_o); end
        checks++; if (W_busy_o !== 32'd0) begin errors++; $display("FAIL midrst_busy: got %h want 0", W_busy_o); end
        checks++; if (M_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %0b want 1", M_ready_o); end
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        checks++; if (W_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_dropped: got %0b want 0", W_valid_o); end
    endtask

`ifdef WB_INSTRET_EN
    task automatic test_instret_wrap();
        @(negedge clk_i);
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        set_push(1'b1, 5'd8, 32'h88, 32'h0, 1'b0, 3'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        release dut.instret_q;
        clear_push();
        #1;
        checks++; if (instret_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL instret_preload: got %h want all ones", instret_o); end
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        checks++; if (instret_o !== 64'd0) begin errors++; $display("FAIL instret_wrap: got %h want 0", instret_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_load_format();
        test_debug_priority();
        test_back_to_back();
        test_busy_reset();
`ifdef WB_INSTRET_EN
        test_instret_wrap();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
